// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: controller state encoding, debounce counter width
// and the idle (released) level of the active-low pushbuttons.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam int   DB_CNT_W      = 4;
  localparam logic KEY_RESET_LVL = 1'b1;

endpackage

// File: rtl/stopwatch_controller_if.sv
// Pushbutton inputs and counter/display controls of the stopwatch controller.
// master = controller side, slave = buttons/counters side; no flow control.
interface stopwatch_controller_if;
  import stopwatch_pkg::*;

  logic   key_start_n;
  logic   key_lap_n;
  logic   key_clear_n;
  logic   cnt_en;
  logic   cnt_clr;
  logic   disp_hold;
  state_t state;

  modport master (
    input  key_start_n, key_lap_n, key_clear_n,
    output cnt_en, cnt_clr, disp_hold, state
  );

  modport slave (
    output key_start_n, key_lap_n, key_clear_n,
    input  cnt_en, cnt_clr, disp_hold, state
  );
endinterface

// File: rtl/stopwatch_controller_key_debouncer.sv
// Key synchronizer plus tick-gated debouncer; press pulse one cycle after the
// accepting tick. Latency SYNC_STAGES cycles + DEBOUNCE_TICKS ticks; no backpressure.
module key_debouncer
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic CLK_50_MHz,
  input  logic reset_n,
  input  logic tick,
  input  logic key_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   deb_q;
  logic [DB_CNT_W-1:0]    stable_q;
  logic                   press_q;
  logic                   key_lvl;

  assign key_lvl = sync_q[SYNC_STAGES-1];
  assign press   = press_q;

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= {SYNC_STAGES{KEY_RESET_LVL}};
      deb_q    <= KEY_RESET_LVL;
      stable_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n};
      press_q <= 1'b0;
      if (tick) begin
        if (key_lvl != deb_q) begin
          // The new level must survive DEBOUNCE_TICKS consecutive ticks.
          if (stable_q == DB_CNT_W'(DEBOUNCE_TICKS - 1)) begin
            deb_q    <= key_lvl;
            stable_q <= '0;
            press_q  <= ~key_lvl;
          end else begin
            stable_q <= stable_q + 1'b1;
          end
        end else begin
          stable_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: 100 Hz tick, key debounce, idle/run/pause/lap sequencing.
// Outputs registered, 1 cycle after tick/press; no backpressure. Lap feature: STOPWATCH_LAP_EN.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   CLK_50_MHz,
  input  logic                   reset_n,
  input  logic                   CLK_100Hz,
  stopwatch_controller_if.master bus
);

  logic   clk100_q;
  logic   tick;
  logic   start_press;
  logic   clear_press;
  state_t state_q;
  logic   cnt_en_q;
  logic   cnt_clr_q;

  assign tick = CLK_100Hz & ~clk100_q;

  key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_start_db (
    .CLK_50_MHz (CLK_50_MHz),
    .reset_n    (reset_n),
    .tick       (tick),
    .key_n      (bus.key_start_n),
    .press      (start_press)
  );

  key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_clear_db (
    .CLK_50_MHz (CLK_50_MHz),
    .reset_n    (reset_n),
    .tick       (tick),
    .key_n      (bus.key_clear_n),
    .press      (clear_press)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_press;
  logic disp_hold_q;

  key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_lap_db (
    .CLK_50_MHz (CLK_50_MHz),
    .reset_n    (reset_n),
    .tick       (tick),
    .key_n      (bus.key_lap_n),
    .press      (lap_press)
  );
`endif

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      clk100_q    <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      disp_hold_q <= 1'b0;
`endif
    end else begin
      clk100_q  <= CLK_100Hz;
      // Uses the pre-transition state, so a tick leaving RUN/LAP still counts.
      cnt_en_q  <= tick & ((state_q == ST_RUN) | (state_q == ST_LAP));
      cnt_clr_q <= 1'b0;
      // Priority clear > start > lap; losing events in the same cycle are dropped.
      if (clear_press) begin
        if (state_q == ST_IDLE) begin
          cnt_clr_q <= 1'b1;
        end else if (state_q == ST_PAUSE) begin
          state_q   <= ST_IDLE;
          cnt_clr_q <= 1'b1;
        end
      end else if (start_press) begin
        state_q <= ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) ? ST_RUN : ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
        disp_hold_q <= 1'b0;
`endif
      end
`ifdef STOPWATCH_LAP_EN
      else if (lap_press) begin
        if (state_q == ST_RUN) begin
          state_q     <= ST_LAP;
          disp_hold_q <= 1'b1;
        end else if (state_q == ST_LAP) begin
          state_q     <= ST_RUN;
          disp_hold_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.cnt_en    = cnt_en_q;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.state     = state_q;
`ifdef STOPWATCH_LAP_EN
  assign bus.disp_hold = disp_hold_q;
`else
  assign bus.disp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_controller.sv
// Stopwatch controller bench: key presses aligned to 100 Hz rises, checked
// against an event-level model of the stopwatch (press accepted iff held >= 2 ticks).
module tb_stopwatch_controller;
  import stopwatch_pkg::*;

  localparam int DEB  = 2;
  localparam int TPER = 6;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic CLK_50_MHz = 1'b0;
  logic reset_n    = 1'b0;
  logic CLK_100Hz  = 1'b0;

  stopwatch_controller_if bus();

  stopwatch_controller #(.DEBOUNCE_TICKS(DEB), .SYNC_STAGES(2)) dut (
    .CLK_50_MHz (CLK_50_MHz),
    .reset_n    (reset_n),
    .CLK_100Hz  (CLK_100Hz),
    .bus        (bus)
  );

  always #5 CLK_50_MHz = ~CLK_50_MHz;

  initial begin
    forever begin
      repeat (TPER / 2) @(posedge CLK_50_MHz);
      #1 CLK_100Hz = ~CLK_100Hz;
    end
  end

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int m_state = 0;
  int m_clr = 0;

  always @(negedge CLK_50_MHz) begin
    if (bus.cnt_en === 1'b1)  en_cnt++;
    if (bus.cnt_clr === 1'b1) clr_cnt++;
  end

  // Stopwatch behaviour as seen by the user, one accepted button event at a time.
  function automatic void model_press(bit s, bit l, bit c);
    if (c) begin
      if (m_state == 0 || m_state == 2) begin
        m_state = 0;
        m_clr++;
      end
    end else if (s) begin
      m_state = (m_state == 1 || m_state == 3) ? 2 : 1;
    end else if (l && LAP_EN) begin
      if (m_state == 1)      m_state = 3;
      else if (m_state == 3) m_state = 1;
    end
  endfunction

  // Hold the selected keys for n whole tick periods from a 100 Hz rise, then release.
  task automatic act(input bit s, input bit l, input bit c, input int n);
    @(posedge CLK_100Hz);
    bus.key_start_n = ~s;
    bus.key_lap_n   = ~l;
    bus.key_clear_n = ~c;
    repeat (TPER * n) @(posedge CLK_50_MHz);
    #1;
    bus.key_start_n = 1'b1;
    bus.key_lap_n   = 1'b1;
    bus.key_clear_n = 1'b1;
    repeat (3 * TPER) @(posedge CLK_50_MHz);
    #1;
    if (n >= DEB) model_press(s, l, c);
  endtask

  task automatic count_en(input int periods, output int delta);
    int e0;
    e0 = en_cnt;
    repeat (TPER * periods) @(posedge CLK_50_MHz);
    #1;
    delta = en_cnt - e0;
  endtask

  task automatic test_reset;
    int bad = 0;
    bus.key_start_n = 1'b1;
    bus.key_lap_n   = 1'b1;
    bus.key_clear_n = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge CLK_50_MHz);
    #1;
    checks++;
    if (bus.state !== ST_IDLE || bus.cnt_en !== 1'b0 || bus.cnt_clr !== 1'b0 || bus.disp_hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_reset: state=%0d en=%b clr=%b hold=%b required 0 0 0 0",
               bus.state, bus.cnt_en, bus.cnt_clr, bus.disp_hold);
    end
    @(negedge CLK_50_MHz);
    reset_n = 1'b1;
    for (int i = 0; i < 10 * TPER; i++) begin
      @(negedge CLK_50_MHz);
      if (bus.state !== ST_IDLE || bus.cnt_en !== 1'b0 || bus.cnt_clr !== 1'b0 || bus.disp_hold !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_idle: %0d cycles with nonzero outputs, required 0", bad);
    end
    m_state = 0;
    m_clr = 0;
    clr_cnt = 0;
  endtask

  task automatic test_start_run;
    int d;
    act(1'b1, 1'b0, 1'b0, 3);
    checks++;
    if (int'(bus.state) !== m_state) begin
      errors++;
      $display("FAIL start_to_run: state=%0d required %0d", bus.state, m_state);
    end
    count_en(5, d);
    checks++;
    if (d !== 5) begin
      errors++;
      $display("FAIL run_cnt_en: pulses=%0d required 5", d);
    end
  endtask

  task automatic test_lap;
    int d;
    for (int k = 0; k < 2; k++) begin
      act(1'b0, 1'b1, 1'b0, 2);
      checks++;
      if (int'(bus.state) !== m_state) begin
        errors++;
        $display("FAIL lap_state[%0d]: state=%0d required %0d", k, bus.state, m_state);
      end
      checks++;
      if (bus.disp_hold !== (m_state == 3)) begin
        errors++;
        $display("FAIL lap_hold[%0d]: disp_hold=%b required %b", k, bus.disp_hold, m_state == 3);
      end
      count_en(3, d);
      checks++;
      if (d !== 3) begin
        errors++;
        $display("FAIL lap_cnt_en[%0d]: pulses=%0d required 3", k, d);
      end
    end
  endtask

  task automatic test_pause_clear;
    int d;
    act(1'b1, 1'b0, 1'b0, 2);
    checks++;
    if (int'(bus.state) !== m_state) begin
      errors++;
      $display("FAIL pause_state: state=%0d required %0d", bus.state, m_state);
    end
    count_en(4, d);
    checks++;
    if (d !== 0) begin
      errors++;
      $display("FAIL pause_cnt_en: pulses=%0d required 0", d);
    end
    act(1'b0, 1'b0, 1'b1, 2);
    checks++;
    if (int'(bus.state) !== m_state) begin
      errors++;
      $display("FAIL clear_state: state=%0d required %0d", bus.state, m_state);
    end
    checks++;
    if (clr_cnt !== m_clr) begin
      errors++;
      $display("FAIL clear_pulses: cnt_clr pulses=%0d required %0d", clr_cnt, m_clr);
    end
  endtask

  task automatic test_simultaneous;
    act(1'b1, 1'b0, 1'b0, 2);
    act(1'b1, 1'b0, 1'b0, 2);
    checks++;
    if (int'(bus.state) !== m_state) begin
      errors++;
      $display("FAIL simul_setup: state=%0d required %0d", bus.state, m_state);
    end
    act(1'b1, 1'b0, 1'b1, 3);
    checks++;
    if (int'(bus.state) !== m_state) begin
      errors++;
      $display("FAIL simul_state: state=%0d required %0d", bus.state, m_state);
    end
    checks++;
    if (clr_cnt !== m_clr) begin
      errors++;
      $display("FAIL simul_clr: cnt_clr pulses=%0d required %0d", clr_cnt, m_clr);
    end
  endtask

  task automatic test_glitch;
    act(1'b1, 1'b0, 1'b0, 1);
    checks++;
    if (int'(bus.state) !== m_state) begin
      errors++;
      $display("FAIL glitch: state=%0d required %0d", bus.state, m_state);
    end
  endtask

  task automatic test_hold_through_reset;
    @(negedge CLK_50_MHz);
    bus.key_start_n = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge CLK_50_MHz);
    reset_n = 1'b1;
    m_state = 0;
    repeat (5 * TPER) @(negedge CLK_50_MHz);
    model_press(1'b1, 1'b0, 1'b0);
    checks++;
    if (int'(bus.state) !== m_state) begin
      errors++;
      $display("FAIL hold_through_reset: state=%0d required %0d", bus.state, m_state);
    end
    bus.key_start_n = 1'b1;
    repeat (3 * TPER) @(posedge CLK_50_MHz);
    #1;
  endtask

  task automatic test_async_reset;
    bit seen = 1'b0;
    act(1'b0, 1'b1, 1'b0, 2);
    for (int i = 0; i < 4 * TPER && !seen; i++) begin
      @(negedge CLK_50_MHz);
      if (bus.cnt_en === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL async_wait_cnt_en: no cnt_en pulse within %0d cycles, required one", 4 * TPER);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== ST_IDLE || bus.cnt_en !== 1'b0 || bus.cnt_clr !== 1'b0 || bus.disp_hold !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d en=%b clr=%b hold=%b required 0 0 0 0",
               bus.state, bus.cnt_en, bus.cnt_clr, bus.disp_hold);
    end
    @(negedge CLK_50_MHz);
    reset_n = 1'b1;
    m_state = 0;
    repeat (2 * TPER) @(posedge CLK_50_MHz);
    #1;
  endtask

  task automatic test_random;
    int d, k, n;
    bit s, l, c;
    for (int i = 0; i < 16; i++) begin
      k = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 3));
      s = (k == 0) || (k == 3);
      l = (k == 1);
      c = (k == 2) || (k == 3);
      act(s, l, c, n);
      checks++;
      if (int'(bus.state) !== m_state) begin
        errors++;
        $display("FAIL rand_state[%0d] keys=%b%b%b ticks=%0d: state=%0d required %0d",
                 i, s, l, c, n, bus.state, m_state);
      end
      checks++;
      if (bus.disp_hold !== (m_state == 3)) begin
        errors++;
        $display("FAIL rand_hold[%0d]: disp_hold=%b required %b", i, bus.disp_hold, m_state == 3);
      end
      checks++;
      if (clr_cnt !== m_clr) begin
        errors++;
        $display("FAIL rand_clr[%0d]: cnt_clr pulses=%0d required %0d", i, clr_cnt, m_clr);
      end
      count_en(2, d);
      checks++;
      if (d !== ((m_state == 1 || m_state == 3) ? 2 : 0)) begin
        errors++;
        $display("FAIL rand_cnt_en[%0d]: pulses=%0d required %0d", i, d,
                 (m_state == 1 || m_state == 3) ? 2 : 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_run();
    test_lap();
    if (m_state == 3) act(1'b0, 1'b1, 1'b0, 2);
    test_pause_clear();
    test_simultaneous();
    test_glitch();
    test_hold_through_reset();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Control FSM for the stopwatch. It sits between the 100 Hz divider output and the centisecond/second/minute counters. It converts the divider's 100 Hz square wave into a one-cycle count tick in the 50 MHz domain, and it debounces the three pushbuttons against that tick. It also sequences the counters through idle, run, pause and lap-hold by driving their enable, clear and display-hold controls.

## Interface
- DEBOUNCE_TICKS, 2: consecutive 10 ms ticks a key must hold a new level before it is accepted (legal 1–15)
- SYNC_STAGES, 2: synchronizer flops per key input (≥2)
- CLK_50_MHz  in  1  system clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- CLK_100Hz  in  1  divider output; a level in the CLK_50_MHz domain; 50 % duty
- key_start_n  in  1  start/stop pushbutton, active-low, asynchronous
- key_lap_n  in  1  lap pushbutton, active-low, asynchronous
- key_clear_n  in  1  clear pushbutton, active-low, asynchronous
- cnt_en  out  1  one-cycle pulse; counters advance one centisecond
- cnt_clr  out  1  one-cycle pulse; counters reset to zero
- disp_hold  out  1  level; display latch freezes the shown time
- state  out  2  IDLE=0, RUN=1, PAUSE=2, LAP=3

## Operation
- Tick: register CLK_100Hz into clk100_q. The tick is CLK_100Hz & ~clk100_q, i.e. one cycle per rising edge of CLK_100Hz.
- Sync: each key passes through SYNC_STAGES flops. These flops reset to 1 (key released).
- Debounce, per key, evaluated only on tick:
  - Synced level ≠ debounced level: increment the stable counter.
  - Equal: clear the stable counter.
  - Counter reaches DEBOUNCE_TICKS: copy the level into the debounced register and clear the counter.
- Press event: one-cycle pulse on the debounced 1→0 transition. A release generates no event.
- Event priority when several keys fire in the same cycle: clear > start > lap. The lower-priority events in that cycle are dropped.
- FSM transitions (anything not listed leaves the state unchanged):
  - IDLE: start→RUN. Clear: stay in IDLE and pulse cnt_clr.
  - RUN: start→PAUSE. Lap→LAP.
  - LAP: lap→RUN. Start→PAUSE. Counting continues in LAP.
  - PAUSE: start→RUN. Clear→IDLE and pulse cnt_clr.
- cnt_en = registered (tick & (state==RUN | state==LAP)). It uses the state register value from the tick cycle.
- disp_hold = 1 exactly while state==LAP.
- Reset values:
  - state=IDLE; cnt_en=0, cnt_clr=0, disp_hold=0.
  - Debounced levels=1; stable counters=0; clk100_q=0.

## Timing
- cnt_en: high for exactly one cycle, 2 cycles after the first edge at which CLK_100Hz samples 1. With the 250000-cycle half period this gives one pulse per 500000 cycles.
- Key press: the event pulse comes 1 cycle after the DEBOUNCE_TICKS-th qualifying tick. state and disp_hold update on the next edge. cnt_clr is registered and appears in that same cycle.
- A tick coinciding with a transition out of RUN/LAP still produces cnt_en. A tick coinciding with a transition into RUN does not.
- A glitch shorter than one tick period is never accepted.
- A key held through reset release produces a press event after DEBOUNCE_TICKS ticks. This is required behaviour.
- Asserting reset_n low mid-count: all outputs return to reset values immediately, with no clock needed.
- If CLK_100Hz stops toggling, all debounce and counting freezes. This is not an error.

## Configuration
- STOPWATCH_LAP_EN defined: the lap key, LAP state and disp_hold behave as specified above.
- STOPWATCH_LAP_EN undefined:
  - The lap synchronizer and debouncer are removed.
  - LAP is unreachable.
  - disp_hold is tied to 0.
  - The state encoding is unchanged.

## Structure
- Package stopwatch_pkg holds:
  - the state encoding constants;
  - the debounce counter width (4 bits);
  - the reset level of the keys.
- Sub-module key_debouncer (synchronizer + tick-gated stable counter + press-event pulse) is instantiated once per key. The lap instance is guarded by STOPWATCH_LAP_EN.

## Test plan
All scenarios run with CLK_100Hz toggling every 3 CLK_50_MHz cycles and DEBOUNCE_TICKS=2.
- Reset with no keys pressed, 10 CLK_100Hz periods: state=0; cnt_en, cnt_clr and disp_hold all 0 throughout.
- Start held low for 3 ticks: state→1 (RUN). cnt_en then pulses once per 6 cycles; count 5 pulses.
- From RUN, lap press: state=3 (LAP), disp_hold=1, cnt_en keeps pulsing. A second lap press gives state=1 and disp_hold=0.
- From RUN, start, then clear: state 1→2 (PAUSE), where cnt_en stops. Clear then gives one cnt_clr pulse and state=0.
- Start and clear debounced on the same tick while in PAUSE: clear wins, cnt_clr=1, state=0.
- Start low for one tick only: no transition. Start held through reset release: state=1 after 2 ticks. Reset_n pulsed low in RUN: outputs go to zero asynchronously.
